// File: rtl/text_pixel_pipe.sv
// text_pixel_pipe: text-mode pixel pipeline in front of the font glyph ROM.
// Turns timing-generator coordinates into a text RAM address, hands the
// character code and cell line to the font ROM, serialises the returned
// glyph row into a 1-bit pixel stream with a blinking underline cursor, and
// delays active/hsync/vsync by the same three cycles as the pixel path.
module text_pixel_pipe #(
  parameter int COLS            = 80,
  parameter int BLINK_BIT       = 5,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [11:0] text_addr,
  input  logic [7:0]  text_data,
  output logic [7:0]  glyph,
  output logic [3:0]  glyph_y,
  input  logic [7:0]  row,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic        pixel,
  output logic        active_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  // Idle (deasserted) level of the sync signals.
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
  localparam logic [11:0] COLS_W = 12'(COLS);

  logic [6:0]  w_col;
  logic [4:0]  w_crow;
  logic [11:0] w_text_addr;
  logic        w_cur_hit;
  logic        w_vs_assert;
  logic        w_blink;
  logic        w_unused_y9;

  // Stage 1 registers
  logic [2:0]  r_px_p1;
  logic        r_cur_p1;
  logic [3:0]  r_gy_p1;
  logic        r_act_p1;
  logic        r_hs_p1;
  logic        r_vs_p1;

  // Stage 2 registers
  logic [2:0]  r_px_p2;
  logic        r_cur_p2;
  logic        r_act_p2;
  logic        r_hs_p2;
  logic        r_vs_p2;

  // Output registers
  logic        r_pixel;
  logic        r_act_p3;
  logic        r_hs_p3;
  logic        r_vs_p3;

  // Blink state
  logic        r_vs_prev;
  logic [5:0]  r_frame_cnt;

  assign w_col       = x[9:3];
  assign w_crow      = y[8:4];
  // Line bit 9 never selects a text row in a 480-line frame.
  assign w_unused_y9 = y[9];

  // Row base is crow*COLS; the 80-column case reduces to two shifts.
  generate
    if (COLS == 80) begin : g_addr80
      assign w_text_addr = {1'b0, w_crow, 6'b0} + {3'b0, w_crow, 4'b0} + {5'b0, w_col};
    end else begin : g_addr_gen
      assign w_text_addr = ({7'd0, w_crow} * COLS_W) + {5'b0, w_col};
    end
  endgenerate

  // Underline cursor occupies the bottom two lines (14, 15) of its cell.
  assign w_cur_hit = cursor_en && (w_col == cursor_col) && (w_crow == cursor_row)
                     && (y[3:0] >= 4'd14);

  // Assertion edge of vsync: idle level last cycle, active level now.
  assign w_vs_assert = (r_vs_prev == SYNC_IDLE) && (vsync_in != SYNC_IDLE);
  assign w_blink     = r_frame_cnt[BLINK_BIT];

  assign text_addr  = w_text_addr;
  assign glyph      = text_data;
  assign glyph_y    = r_gy_p1;
  assign pixel      = r_pixel;
  assign active_out = r_act_p3;
  assign hsync_out  = r_hs_p3;
  assign vsync_out  = r_vs_p3;

  // Stage 1: capture pixel phase, cursor hit, cell line and control in step with the RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_px_p1  <= 3'd0;
      r_cur_p1 <= 1'b0;
      r_gy_p1  <= 4'd0;
      r_act_p1 <= 1'b0;
      r_hs_p1  <= SYNC_IDLE;
      r_vs_p1  <= SYNC_IDLE;
    end else begin
      r_px_p1  <= x[2:0];
      r_cur_p1 <= w_cur_hit;
      r_gy_p1  <= y[3:0];
      r_act_p1 <= active_in;
      r_hs_p1  <= hsync_in;
      r_vs_p1  <= vsync_in;
    end
  end

  // Stage 2: carry side information alongside the font ROM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_px_p2  <= 3'd0;
      r_cur_p2 <= 1'b0;
      r_act_p2 <= 1'b0;
      r_hs_p2  <= SYNC_IDLE;
      r_vs_p2  <= SYNC_IDLE;
    end else begin
      r_px_p2  <= r_px_p1;
      r_cur_p2 <= r_cur_p1;
      r_act_p2 <= r_act_p1;
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
    end
  end

  // Output stage: select the glyph bit (bit 0 = leftmost), apply cursor XOR, blank outside the visible area.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pixel  <= 1'b0;
      r_act_p3 <= 1'b0;
      r_hs_p3  <= SYNC_IDLE;
      r_vs_p3  <= SYNC_IDLE;
    end else begin
      r_pixel  <= r_act_p2 & (row[r_px_p2] ^ (r_cur_p2 & w_blink));
      r_act_p3 <= r_act_p2;
      r_hs_p3  <= r_hs_p2;
      r_vs_p3  <= r_vs_p2;
    end
  end

  // Frame counter advances on each vsync assertion; its selected bit is the blink phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_prev   <= SYNC_IDLE;
      r_frame_cnt <= 6'd0;
    end else begin
      r_vs_prev <= vsync_in;
      if (w_vs_assert) begin
        r_frame_cnt <= r_frame_cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_text_pixel_pipe.sv
// tb_text_pixel_pipe: directed bench for text_pixel_pipe with a one-cycle
// text RAM model and a one-cycle font ROM model.
module tb_text_pixel_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        active_in;
  logic        hsync_in;
  logic        vsync_in;
  logic [11:0] text_addr;
  logic [7:0]  text_data;
  logic [7:0]  glyph;
  logic [3:0]  glyph_y;
  logic [7:0]  row;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        pixel;
  logic        active_out;
  logic        hsync_out;
  logic        vsync_out;

  logic [7:0]  ram_char;
  logic [7:0]  font_fill;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  text_pixel_pipe #(.COLS(80), .BLINK_BIT(5), .SYNC_ACTIVE_LOW(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .y          (y),
    .active_in  (active_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .text_addr  (text_addr),
    .text_data  (text_data),
    .glyph      (glyph),
    .glyph_y    (glyph_y),
    .row        (row),
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .pixel      (pixel),
    .active_out (active_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out)
  );

  // Text RAM: one cycle read latency, every cell holds ram_char.
  always @(posedge clk) text_data <= ram_char;

  // Font ROM: one cycle read latency; 'A' = 0x81, 'B' = 0x03, else font_fill.
  always @(posedge clk)
    row <= (glyph == 8'h41) ? 8'h81 : ((glyph == 8'h42) ? 8'h03 : font_fill);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed 8 visible pixels from x0 on line yy and check them 3 cycles later.
  task automatic run_px(input int x0, input int yy, input logic [7:0] exp_bits, input string tag);
    y = 10'(yy);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        x = 10'(x0 + i);
        active_in = 1'b1;
      end else begin
        active_in = 1'b0;
      end
      step();
      if (i >= 2) chk($sformatf("%s[%0d]", tag, i - 2), {31'd0, pixel}, {31'd0, exp_bits[i - 2]});
    end
    active_in = 1'b0;
    step();
  endtask

  task automatic vs_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      vsync_in = 1'b0;
      step();
      vsync_in = 1'b1;
      step();
    end
  endtask

  initial begin
    rst = 1'b1; x = '0; y = 10'd5; active_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    cursor_en = 1'b0; cursor_col = 7'd3; cursor_row = 5'd2; ram_char = 8'h00; font_fill = 8'h00;

    // Reset state
    step(); step();
    chk("rst_pixel", {31'd0, pixel}, 32'd0);
    chk("rst_active", {31'd0, active_out}, 32'd0);
    chk("rst_hsync", {31'd0, hsync_out}, 32'd1);
    chk("rst_vsync", {31'd0, vsync_out}, 32'd1);
    chk("rst_glyph_y", {28'd0, glyph_y}, 32'd0);
    rst = 1'b0;

    // Address arithmetic (combinational)
    x = 10'd632; y = 10'd477; #1;
    chk("addr_2399", {20'd0, text_addr}, 32'd2399);
    x = 10'd0; y = 10'd16; #1;
    chk("addr_80", {20'd0, text_addr}, 32'd80);
    x = 10'd15; y = 10'd0; #1;
    chk("addr_1", {20'd0, text_addr}, 32'd1);
    step();
    y = 10'd7; step(); step();
    chk("glyph_y_dly", {28'd0, glyph_y}, 32'd7);

    // Serialisation: 0x41 -> 0x81 symmetric, 0x42 -> 0x03 checks bit order
    ram_char = 8'h41; y = 10'd0; step(); step(); step();
    run_px(8, 0, 8'b1000_0001, "ser41");
    ram_char = 8'h42; step(); step(); step();
    run_px(0, 0, 8'b0000_0011, "ser42");
    #1 chk("glyph_eq", {24'd0, glyph}, 32'h42);

    // Sync alignment: hsync low cycles 10..105, vsync low 20..22
    ram_char = 8'h00;
    for (int c = 0; c < 120; c++) begin
      hsync_in = (c >= 10 && c <= 105) ? 1'b0 : 1'b1;
      vsync_in = (c >= 20 && c <= 22) ? 1'b0 : 1'b1;
      step();
      chk($sformatf("hsync_c%0d", c + 1), {31'd0, hsync_out},
          ((c + 1 >= 13) && (c + 1 <= 108)) ? 32'd0 : 32'd1);
      chk($sformatf("vsync_c%0d", c + 1), {31'd0, vsync_out},
          ((c + 1 >= 23) && (c + 1 <= 25)) ? 32'd0 : 32'd1);
    end
    hsync_in = 1'b1; vsync_in = 1'b1;

    // active_in low blanks a full glyph row
    font_fill = 8'hFF; x = '0; y = '0; active_in = 1'b0;
    step(); step(); step(); step();
    chk("blank_pixel", {31'd0, pixel}, 32'd0);
    active_in = 1'b1; step(); step(); step();
    chk("unblank_pixel", {31'd0, pixel}, 32'd1);
    chk("unblank_active", {31'd0, active_out}, 32'd1);
    active_in = 1'b0; step(); step(); step();

    // Clean restart clears frame counter
    rst = 1'b1; step(); rst = 1'b0; step();

    // Cursor blink
    font_fill = 8'h00; cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 5'd2;
    run_px(24, 46, 8'h00, "cur_off");
    vs_pulse(32);
    run_px(24, 46, 8'hFF, "cur_on");
    run_px(24, 45, 8'h00, "cur_y45");
    run_px(32, 46, 8'h00, "cur_col4");
    cursor_en = 1'b0;
    run_px(24, 46, 8'h00, "cur_dis");
    cursor_en = 1'b1;

    // Reset mid-stream
    ram_char = 8'h41; x = 10'd8; y = 10'd0; active_in = 1'b1;
    step(); step(); step();
    chk("pre_rst_pixel", {31'd0, pixel}, 32'd1);
    rst = 1'b1; step();
    chk("mrst_pixel", {31'd0, pixel}, 32'd0);
    chk("mrst_active", {31'd0, active_out}, 32'd0);
    chk("mrst_hsync", {31'd0, hsync_out}, 32'd1);
    rst = 1'b0; step();
    chk("post1_pixel", {31'd0, pixel}, 32'd0);
    step();
    chk("post2_active", {31'd0, active_out}, 32'd0);
    step();
    chk("post3_pixel", {31'd0, pixel}, 32'd1);
    chk("post3_active", {31'd0, active_out}, 32'd1);
    active_in = 1'b0; ram_char = 8'h00; step(); step(); step();
    run_px(24, 46, 8'h00, "rst_blink");

    // Frame counter wrap
    vs_pulse(32);
    run_px(24, 46, 8'hFF, "wrap32");
    vs_pulse(32);
    run_px(24, 46, 8'h00, "wrap64");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_pixel_pipe.md
# text_pixel_pipe

Text-mode pixel pipeline sitting directly upstream of the `font` glyph ROM. From the VGA timing generator's pixel coordinates it forms the text-buffer address, passes the returned character code and cell row to `font`, and serialises the returned 8-pixel glyph row into a 1-bit pixel stream. The stream carries a blinking underline cursor. Sync and blank signals are delayed to stay aligned with the pixel stream.

## Interface
Parameters:
- `COLS`, 80: characters per text row; address multiplier.
- `BLINK_BIT`, 5: frame-counter bit used as blink phase (toggles every 32 frames).
- `SYNC_ACTIVE_LOW`, 1: polarity of `hsync_in`/`vsync_in` and of their delayed copies.

Ports:
- `clk` in 1: pixel clock; the single clock of the block.
- `rst` in 1: reset; synchronous, active-high.
- `x` in 10: current pixel column from the timing generator.
- `y` in 10: current pixel line.
- `active_in` in 1: visible-area flag for (`x`,`y`).
- `hsync_in` in 1: horizontal sync for (`x`,`y`).
- `vsync_in` in 1: vertical sync for (`x`,`y`).
- `text_addr` out 12: text RAM read address (combinational from `x`,`y`).
- `text_data` in 8: character code from text RAM; valid one cycle after `text_addr`.
- `glyph` out 8: to `font.glyph`; equals `text_data` (combinational).
- `glyph_y` out 4: to `font.y`; equals `y[3:0]` delayed 1 cycle.
- `row` in 8 [0:7]: from `font.row`; bit 0 is the leftmost pixel; valid one cycle after `glyph`/`glyph_y`.
- `cursor_en` in 1: cursor enable.
- `cursor_col` in 7: cursor column, 0..79.
- `cursor_row` in 5: cursor text row, 0..29.
- `pixel` out 1: foreground(1)/background(0), registered.
- `active_out` out 1: `active_in` delayed 3 cycles.
- `hsync_out` out 1: `hsync_in` delayed 3 cycles.
- `vsync_out` out 1: `vsync_in` delayed 3 cycles.

## Operation
- Cell coordinates: `col = x[9:3]`, `crow = y[8:4]`.
- Address: `text_addr = crow*COLS + col`, truncated to 12 bits. For COLS=80 it is built as `(crow<<6)+(crow<<4)+col`.
  - Range is 0..2399 inside the 640x480 area.
  - Outside the visible area the address is unconstrained. Its data is discarded because `active_out`=0.
- Stage 1 (cycle n+1):
  - `glyph` = `text_data`.
  - `glyph_y` = registered `y[3:0]`.
  - `x[2:0]` registered to `px1`.
  - Cursor-hit registered to `cur1`. Cursor-hit = `cursor_en && col==cursor_col && crow==cursor_row && y[3:0]>=14`.
- Stage 2 (cycle n+2):
  - `row` valid.
  - `px1`→`px2`, `cur1`→`cur2`.
- Output register (cycle n+3):
  - `pixel <= active_d2 & (row[px2] ^ (cur2 & blink))`, where `active_d2` is `active_in` delayed 2 cycles.
  - `active_out`, `hsync_out`, `vsync_out` are 3-stage delay lines.
- Blink:
  - 6-bit `frame_cnt` increments on the assertion edge of `vsync_in`. That edge is 1→0 when SYNC_ACTIVE_LOW, else 0→1; detect it with a registered previous value.
  - `blink = frame_cnt[BLINK_BIT]`. `frame_cnt` wraps 63→0.
  - The cursor is a 2-line underline (cell lines 14–15), XOR-inverting glyph pixels.
- Cursor inputs are sampled with `x`/`y` in cycle n. Changes mid-line take effect 3 cycles later on the pixel stream.

## Timing
- Fixed latency: inputs in cycle n → `pixel`/`active_out`/`hsync_out`/`vsync_out` in cycle n+3. No stalls, no handshake; one pixel per clock.
- `text_addr` and `glyph` are combinational. Text RAM and `font` must each have exactly one cycle of synchronous read latency.
- Reset values (first cycle after `rst` sampled high):
  - `pixel`=0, `active_out`=0.
  - `hsync_out`/`vsync_out` = inactive level (1 if SYNC_ACTIVE_LOW).
  - `glyph_y`=0, `frame_cnt`=0, all delay-line stages cleared.
  - The vsync edge detector's previous-value register resets to the inactive level, so no spurious count follows reset.
- Reset asserted mid-line:
  - Outputs go to reset values on the next edge.
  - After release, 3 cycles pass before outputs reflect inputs again; the cleared delay stages hold inactive/0.
- Simultaneous vsync edge and cursor hit: the count updates on that edge. The new blink value applies to pixels output from the following cycle.

## Test plan
- Address math: x=632, y=477 → `text_addr`=2399 in the same cycle. x=0, y=16 → 80. x=15, y=0 → 1.
- Latency/serialisation:
  - Stimulus: text_data=0x41, font model returns row=0b10000001; x sweeps 8..15 with active_in=1 from cycle n.
  - Required: `pixel` = 1,0,0,0,0,0,0,1 in cycles n+3..n+10.
- Sync alignment: a `hsync_in` pulse low for cycles 10–105 → `hsync_out` low exactly in cycles 13–108. `active_in`=0 forces `pixel`=0 even with row=0xFF.
- Cursor blink:
  - Setup: cursor_en=1, cursor_col=3, cursor_row=2, row=0x00.
  - Pixels x=24..31, y=46: `pixel`=0 while frame_cnt[5]=0.
  - After 32 vsync assertions: same pixels =1. Line y=45 stays 0.
- Reset mid-stream: `rst` high one cycle during active video → next cycle `pixel`=0, `active_out`=0, `hsync_out`=1. Correct pixels resume 3 cycles after release; `frame_cnt` reads 0.
- Wrap: 64 vsync assertions → `frame_cnt` back to 0, blink phase off.
